wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of pending-write FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter XLEN, default 64, sets the data width and SHALL match `REG_BUS.
REQ-003 clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  is an asynchronous, active-high reset.
REQ-005 alu_valid, alu_rd_en, alu_rd_index[4:0], alu_rd_data[XLEN-1:0]  in  carry the execute-stage result.
REQ-006 alu_ready  out  1  means this cycle's ALU offer is accepted.
REQ-007 lsu_valid, lsu_rd_en, lsu_rd_index[4:0], lsu_rd_data[XLEN-1:0]  in  carry the load-response result.
REQ-008 lsu_ready  out  1  means this cycle's LSU offer is accepted.
REQ-009 rd_en  out  1, rd_index  out  5 and rd_data  out  XLEN form the regfile write port, driven from registers.
REQ-010 rs1_index, rs2_index  in  5  are the decode read indices used for forwarding lookup.
REQ-011 rs1_hit, rs2_hit  out  1 and rs1_fwd, rs2_fwd  out  XLEN carry the forwarded pending write.
REQ-012 wb_idle  out  1  means no write is pending in the block.

Function
REQ-013 A handshake SHALL occur on a source in any cycle where its valid and ready are both high.
REQ-014 Ready SHALL be computed from the registered count only, giving no same-cycle credit for a dequeue; free = DEPTH - count.
REQ-015 lsu_ready = (free >= 1).
REQ-016 alu_ready = (free >= 2) OR (free >= 1 AND NOT lsu_valid); the LSU has priority for the last free slot.
REQ-017 A handshaked entry with rd_en = 0 or rd_index = 0 SHALL be dropped: handshake completes, nothing is enqueued.
REQ-018 When both sources enqueue in the same cycle, the LSU entry SHALL be enqueued first (older) and the ALU entry second.
REQ-019 Pop rule: on each edge where count > 0, the head entry SHALL be popped into the output register and rd_en set to 1; otherwise rd_en SHALL be set to 0.
REQ-020 Timing: with the FIFO empty, handshake in cycle C SHALL give rd_en = 1 in cycle C+2, high for exactly one cycle per entry.
REQ-021 Throughput SHALL be one regfile write per cycle; a simultaneous push and pop SHALL update count by (pushes - 1).
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-023 Writes SHALL reach rd_* strictly in enqueue order.
REQ-024 Forward search for rsX_index != 0 SHALL cover all valid FIFO entries plus the output register when rd_en = 1.
REQ-025 The youngest match SHALL win, in priority order: FIFO tail-most, then FIFO head, then output register.
REQ-026 With no match, or rsX_index = 0, rsX_hit SHALL be 0 and rsX_fwd SHALL be 0.
REQ-027 Forwarding SHALL be combinational, and same-cycle incoming offers SHALL NOT be searched.
REQ-028 wb_idle = (count == 0) AND NOT rd_en.

Reset
REQ-029 Asserting rst at any time, including mid-drain, SHALL immediately clear count, pointers, rd_en, rd_index and rd_data to 0.
REQ-030 During and after reset, lsu_ready and alu_ready SHALL be 1 and wb_idle SHALL be 1; FIFO data storage need not be cleared.
REQ-031 Entries pending at reset SHALL be discarded and never written.

Verification
REQ-032 Single ALU write: ALU x5 = 0x11 in cycle 0 -> rd_en = 1, rd_index = 5, rd_data = 0x11 in cycle 2 only; wb_idle = 1 from cycle 3.
REQ-033 Simultaneous offers: LSU x3 = 0xA and ALU x4 = 0xB in cycle 0 -> x3 written in cycle 2, x4 in cycle 3.
REQ-034 Full and priority: fill to count = 3 (DEPTH 4), then offer both -> lsu_ready = 1, alu_ready = 0; ALU is accepted the next cycle after a pop.
REQ-035 Drop rule: ALU offer with rd_index = 0, then LSU offer with rd_en = 0 -> both handshake, no rd_en pulse, wb_idle stays 1.
REQ-036 Forwarding: queue x7 = 1 then x7 = 2 with rs1_index = 7 -> rs1_hit = 1, rs1_fwd = 2; hit continues until the second write leaves the output register.
REQ-037 Reset mid-drain: three entries queued, rst pulsed -> rd_en = 0 immediately, no further writes, count = 0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/LSU offers, regfile write port,
// forwarding lookup and idle status.
interface wb_arbiter_if #(
   parameter int XLEN = 64
);
   logic            alu_valid;
   logic            alu_rd_en;
   logic [4:0]      alu_rd_index;
   logic [XLEN-1:0] alu_rd_data;
   logic            alu_ready;

   logic            lsu_valid;
   logic            lsu_rd_en;
   logic [4:0]      lsu_rd_index;
   logic [XLEN-1:0] lsu_rd_data;
   logic            lsu_ready;

   logic            rd_en;
   logic [4:0]      rd_index;
   logic [XLEN-1:0] rd_data;

   logic [4:0]      rs1_index;
   logic [4:0]      rs2_index;
   logic            rs1_hit;
   logic            rs2_hit;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   logic            wb_idle;

   modport slave (
      input  alu_valid, alu_rd_en, alu_rd_index, alu_rd_data,
      output alu_ready,
      input  lsu_valid, lsu_rd_en, lsu_rd_index, lsu_rd_data,
      output lsu_ready,
      output rd_en, rd_index, rd_data,
      input  rs1_index, rs2_index,
      output rs1_hit, rs2_hit, rs1_fwd, rs2_fwd,
      output wb_idle
   );

   modport master (
      output alu_valid, alu_rd_en, alu_rd_index, alu_rd_data,
      input  alu_ready,
      output lsu_valid, lsu_rd_en, lsu_rd_index, lsu_rd_data,
      input  lsu_ready,
      input  rd_en, rd_index, rd_data,
      output rs1_index, rs2_index,
      input  rs1_hit, rs2_hit, rs1_fwd, rs2_fwd,
      input  wb_idle
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results through a small
// pending-write FIFO into one regfile write port, with forwarding.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]      idx_q [DEPTH];
   logic [XLEN-1:0] dat_q [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_p1;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   free;
   logic            rd_en_q, rd_en_d;
   logic [4:0]      rd_index_q, rd_index_d;
   logic [XLEN-1:0] rd_data_q, rd_data_d;

   logic            lsu_push, alu_push, pop;
   logic [1:0]      n_push;
   logic            we0, we1;
   logic [4:0]      w0_idx;
   logic [XLEN-1:0] w0_dat;

   logic            rs1_hit, rs2_hit;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;
   logic [PW-1:0]   slot;

   // Ready looks only at the registered count; LSU owns the last slot.
   assign free          = DEPTH_C - count_q;
   assign bus.lsu_ready = (free != '0);
   assign bus.alu_ready = (free >= CW'(2)) ||
                          ((free != '0) && !bus.lsu_valid);

   assign lsu_push = bus.lsu_valid && bus.lsu_ready &&
                     bus.lsu_rd_en && (bus.lsu_rd_index != '0);
   assign alu_push = bus.alu_valid && bus.alu_ready &&
                     bus.alu_rd_en && (bus.alu_rd_index != '0);
   assign pop      = (count_q != '0);
   assign wr_ptr_p1 = wr_ptr_q + PW'(1);

   always_comb begin
      n_push = {1'b0, lsu_push} + {1'b0, alu_push};
      we0    = lsu_push || alu_push;
      we1    = lsu_push && alu_push;
      w0_idx = lsu_push ? bus.lsu_rd_index : bus.alu_rd_index;
      w0_dat = lsu_push ? bus.lsu_rd_data : bus.alu_rd_data;

      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(n_push) - CW'(pop);

      rd_en_d    = pop;
      rd_index_d = rd_index_q;
      rd_data_d  = rd_data_q;
      if (pop) begin
         rd_index_d = idx_q[rd_ptr_q];
         rd_data_d  = dat_q[rd_ptr_q];
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (we0) begin
         idx_q[wr_ptr_q] <= w0_idx;
         dat_q[wr_ptr_q] <= w0_dat;
      end
      if (we1) begin
         idx_q[wr_ptr_p1] <= bus.alu_rd_index;
         dat_q[wr_ptr_p1] <= bus.alu_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_en_q    <= 1'b0;
         rd_index_q <= '0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_en_q    <= rd_en_d;
         rd_index_q <= rd_index_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Scan oldest to youngest so later matches override earlier ones.
   always_comb begin
      rs1_hit = 1'b0;
      rs1_fwd = '0;
      rs2_hit = 1'b0;
      rs2_fwd = '0;
      slot    = rd_ptr_q;
      if (rd_en_q && (rd_index_q == bus.rs1_index)) begin
         rs1_hit = 1'b1;
         rs1_fwd = rd_data_q;
      end
      if (rd_en_q && (rd_index_q == bus.rs2_index)) begin
         rs2_hit = 1'b1;
         rs2_fwd = rd_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (idx_q[slot] == bus.rs1_index) begin
               rs1_hit = 1'b1;
               rs1_fwd = dat_q[slot];
            end
            if (idx_q[slot] == bus.rs2_index) begin
               rs2_hit = 1'b1;
               rs2_fwd = dat_q[slot];
            end
         end
      end
      if (bus.rs1_index == '0) begin
         rs1_hit = 1'b0;
         rs1_fwd = '0;
      end
      if (bus.rs2_index == '0) begin
         rs2_hit = 1'b0;
         rs2_fwd = '0;
      end
   end

   assign bus.rs1_hit  = rs1_hit;
   assign bus.rs1_fwd  = rs1_fwd;
   assign bus.rs2_hit  = rs2_hit;
   assign bus.rs2_fwd  = rs2_fwd;
   assign bus.rd_en    = rd_en_q;
   assign bus.rd_index = rd_index_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.wb_idle  = (count_q == '0) && !rd_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus
// random traffic against a queue-based reference model.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int XLEN  = 64;

   typedef struct {
      logic [4:0]  idx;
      logic [63:0] dat;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_arbiter_if #(.XLEN(XLEN)) bus ();

   wb_arbiter #(
      .DEPTH(DEPTH),
      .XLEN (XLEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   ent_t q[$];
   ent_t o;
   logic o_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic void fwd(input logic [4:0] rs,
                               output logic hit,
                               output logic [63:0] val);
      hit = 1'b0;
      val = '0;
      if (rs == 5'd0) return;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].idx == rs) begin
            hit = 1'b1;
            val = q[i].dat;
            return;
         end
      end
      if (o_en && o.idx == rs) begin
         hit = 1'b1;
         val = o.dat;
      end
   endfunction

   task automatic alu(input logic v, input logic en,
                      input logic [4:0] idx, input logic [63:0] d);
      bus.alu_valid    = v;
      bus.alu_rd_en    = en;
      bus.alu_rd_index = idx;
      bus.alu_rd_data  = d;
   endtask

   task automatic lsu(input logic v, input logic en,
                      input logic [4:0] idx, input logic [63:0] d);
      bus.lsu_valid    = v;
      bus.lsu_rd_en    = en;
      bus.lsu_rd_index = idx;
      bus.lsu_rd_data  = d;
   endtask

   task automatic model_reset();
      q.delete();
      o_en = 1'b0;
   endtask

   // Called just after a falling edge with inputs settled.
   task automatic cycle();
      int          free;
      logic        lr, ar, h;
      logic [63:0] v;
      #1;
      free = DEPTH - q.size();
      lr = (free >= 1);
      ar = (free >= 2) || (free >= 1 && !bus.lsu_valid);
      chk("lsu_ready", bus.lsu_ready, lr);
      chk("alu_ready", bus.alu_ready, ar);
      chk("rd_en", bus.rd_en, o_en);
      if (o_en) begin
         chk("rd_index", bus.rd_index, o.idx);
         chk("rd_data", bus.rd_data, o.dat);
      end
      chk("wb_idle", bus.wb_idle, q.size() == 0 && !o_en);
      fwd(bus.rs1_index, h, v);
      chk("rs1_hit", bus.rs1_hit, h);
      chk("rs1_fwd", bus.rs1_fwd, v);
      fwd(bus.rs2_index, h, v);
      chk("rs2_hit", bus.rs2_hit, h);
      chk("rs2_fwd", bus.rs2_fwd, v);
      if (rst) begin
         model_reset();
      end else begin
         if (q.size() > 0) begin
            o    = q.pop_front();
            o_en = 1'b1;
         end else begin
            o_en = 1'b0;
         end
         if (bus.lsu_valid && lr && bus.lsu_rd_en &&
             bus.lsu_rd_index != 0)
            q.push_back('{bus.lsu_rd_index, bus.lsu_rd_data});
         if (bus.alu_valid && ar && bus.alu_rd_en &&
             bus.alu_rd_index != 0)
            q.push_back('{bus.alu_rd_index, bus.alu_rd_data});
      end
      @(negedge clk);
   endtask

   initial begin
      alu(0, 0, 0, 0);
      lsu(0, 0, 0, 0);
      bus.rs1_index = 0;
      bus.rs2_index = 0;
      @(negedge clk);
      repeat (3) cycle();
      rst = 1'b0;

      // single ALU write
      alu(1, 1, 5, 64'h11);
      cycle();
      alu(0, 0, 0, 0);
      cycle();
      #1;
      chk("t032_en", bus.rd_en, 1);
      chk("t032_idx", bus.rd_index, 5);
      chk("t032_dat", bus.rd_data, 64'h11);
      cycle();
      #1;
      chk("t032_idle", bus.wb_idle, 1);
      cycle();

      // simultaneous offers, LSU older
      lsu(1, 1, 3, 64'hA);
      alu(1, 1, 4, 64'hB);
      cycle();
      lsu(0, 0, 0, 0);
      alu(0, 0, 0, 0);
      cycle();
      #1;
      chk("t033_first", bus.rd_index, 3);
      cycle();
      #1;
      chk("t033_second", bus.rd_index, 4);
      repeat (2) cycle();

      // fill to three then contend for the last slot
      lsu(1, 1, 8, 64'h80);
      alu(1, 1, 9, 64'h90);
      cycle();
      lsu(1, 1, 10, 64'hA0);
      alu(1, 1, 11, 64'hB0);
      cycle();
      lsu(1, 1, 12, 64'hC0);
      alu(1, 1, 13, 64'hD0);
      #1;
      chk("t034_lsu_rdy", bus.lsu_ready, 1);
      chk("t034_alu_rdy", bus.alu_ready, 0);
      cycle();
      lsu(0, 0, 0, 0);
      #1;
      chk("t034_alu_next", bus.alu_ready, 1);
      cycle();
      alu(0, 0, 0, 0);
      repeat (6) cycle();

      // drop rule
      alu(1, 1, 0, 64'h55);
      cycle();
      alu(0, 0, 0, 0);
      lsu(1, 0, 9, 64'h66);
      cycle();
      lsu(0, 0, 0, 0);
      repeat (3) begin
         #1;
         chk("t035_idle", bus.wb_idle, 1);
         cycle();
      end

      // forwarding youngest wins
      bus.rs1_index = 7;
      alu(1, 1, 7, 64'h1);
      cycle();
      alu(1, 1, 7, 64'h2);
      cycle();
      alu(0, 0, 0, 0);
      #1;
      chk("t036_hit", bus.rs1_hit, 1);
      chk("t036_fwd", bus.rs1_fwd, 64'h2);
      repeat (4) cycle();
      bus.rs1_index = 0;

      // reset mid-drain
      lsu(1, 1, 1, 64'h101);
      alu(1, 1, 2, 64'h102);
      cycle();
      lsu(0, 0, 0, 0);
      alu(1, 1, 6, 64'h106);
      cycle();
      alu(0, 0, 0, 0);
      cycle();
      #2;
      rst = 1'b1;
      #1;
      chk("t037_rd_en", bus.rd_en, 0);
      chk("t037_idle", bus.wb_idle, 1);
      chk("t037_rdy", bus.alu_ready, 1);
      model_reset();
      @(negedge clk);
      cycle();
      rst = 1'b0;
      repeat (5) cycle();

      // random traffic
      repeat (3000) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            model_reset();
         end else begin
            rst = 1'b0;
         end
         alu($urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
             5'($urandom_range(0, 7)), {$urandom, $urandom});
         lsu($urandom_range(0, 99) < 40, $urandom_range(0, 9) != 0,
             5'($urandom_range(0, 7)), {$urandom, $urandom});
         bus.rs1_index = 5'($urandom_range(0, 7));
         bus.rs2_index = 5'($urandom_range(0, 7));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
